// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared definitions for the RMII receive control path --
// state encodings, header field sizes, error codes and the CRC-32 constants.
package eth_rx_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PREAMBLE  = 4'd1,
    DEST_ADDR = 4'd3,
    SRC_ADDR  = 4'd4,
    LEN_TYPE  = 4'd5,
    DATA      = 4'd6,
    DONE      = 4'd8,
    DROP      = 4'd9
  } rx_state_e;

  localparam int pMAC_Addr_Cnt = 6;
  localparam int pLen_Type_Cnt = 2;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_CRC   = 3'd1;
  localparam logic [2:0] ERR_RUNT  = 3'd2;
  localparam logic [2:0] ERR_GIANT = 3'd3;
  localparam logic [2:0] ERR_ALIGN = 3'd4;
  localparam logic [2:0] ERR_RX_ER = 3'd5;
  localparam logic [2:0] ERR_OVF   = 3'd6;
  localparam logic [2:0] ERR_ADDR  = 3'd7;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  // Reflected CRC-32 advanced by one byte, bit 0 first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r >> 1) ^ (CRC_POLY & {32{r[0] ^ d[i]}});
    return r;
  endfunction

endpackage

// File: rtl/eth_rx_crc32.sv
// eth_rx_crc32: byte-wide reflected CRC-32. Crc reflects a byte one cycle
// after En; Init reloads the all-ones seed.
module eth_rx_crc32
  import eth_rx_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Init,
  input  logic        En,
  input  logic [7:0]  Data,
  output logic [31:0] Crc
);

  // CRC register: seed on reset/Init, advance one byte per En.
  always_ff @(posedge Clk) begin
    if (Rst || Init) Crc <= 32'hFFFFFFFF;
    else if (En)     Crc <= crc32_byte(Crc, Data);
  end

endmodule

// File: rtl/eth_rx_ctrl.sv
// eth_rx_ctrl: RMII receive control. Locks to preamble/SFD, assembles bytes
// LSB-first, writes every post-SFD byte to the rx FIFO and issues one
// Pkt_Done per frame with a prioritised error code.
// Optional destination address filter: define ETH_RX_ADDR_FILTER_EN.
module eth_rx_ctrl
  import eth_rx_pkg::*;
#(
  parameter int          pMin_Preamble_Dibits = 8,
  parameter int          pMin_Frame_Bytes     = 64,
  parameter int          pMax_Frame_Bytes     = 1518,
  parameter logic [47:0] pMAC_Addr            = 48'h02_00_00_00_00_01
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  Rxd,
  input  logic        Crs_Dv,
  input  logic        Rx_Er,
  input  logic        Fifo_Full,
  output logic        Fifo_Wr,
  output logic [7:0]  Fifo_Wr_Data,
  output logic [3:0]  Rx_Ctrl_FSM_State,
  output logic [10:0] Byte_Cnt,
  output logic        Pkt_Done,
  output logic        Pkt_Good,
  output logic [2:0]  Pkt_Err_Code
);

  localparam logic [10:0] MIN_BYTES = 11'(pMin_Frame_Bytes);
  localparam logic [10:0] MAX_BYTES = 11'(pMax_Frame_Bytes);
  localparam logic [7:0]  MIN_PRE   = 8'(pMin_Preamble_Dibits);
  localparam logic [10:0] END_DST   = 11'(pMAC_Addr_Cnt - 1);
  localparam logic [10:0] END_SRC   = 11'(2 * pMAC_Addr_Cnt - 1);
  localparam logic [10:0] END_LT    = 11'(2 * pMAC_Addr_Cnt + pLen_Type_Cnt - 1);

  rx_state_e   state, nxt_state;
  logic        wait_quiet;
  logic [7:0]  pre_cnt;
  logic [1:0]  dib_cnt;
  logic [5:0]  byte_buf;
  logic [10:0] byte_cnt;
  logic        rx_er_seen, ovf_seen, giant_seen, addr_miss;
  logic        take_dibit, byte_done, wr_en, set_rx_er, set_ovf, set_giant;
  logic [7:0]  byte_nxt;
  logic [2:0]  err_code;
  logic [31:0] crc;

  assign byte_nxt          = {Rxd, byte_buf};
  assign Rx_Ctrl_FSM_State = state;
  assign Byte_Cnt          = byte_cnt;

  eth_rx_crc32 u_crc (
    .Clk  (Clk),
    .Rst  (Rst),
    .Init (state == IDLE),
    .En   (wr_en),
    .Data (byte_nxt),
    .Crc  (crc)
  );

  // Next state and per-cycle datapath strobes.
  always_comb begin
    nxt_state  = state;
    take_dibit = 1'b0;
    byte_done  = 1'b0;
    wr_en      = 1'b0;
    set_rx_er  = 1'b0;
    set_ovf    = 1'b0;
    set_giant  = 1'b0;
    case (state)
      IDLE:
        if (!wait_quiet && Crs_Dv && Rxd == 2'b01) nxt_state = PREAMBLE;
      PREAMBLE:
        if (!Crs_Dv)                              nxt_state = IDLE;
        else if (Rxd == 2'b11 && pre_cnt >= MIN_PRE) nxt_state = DEST_ADDR;
        else if (Rxd != 2'b01)                    nxt_state = IDLE;
      DEST_ADDR, SRC_ADDR, LEN_TYPE, DATA: begin
        if (!Crs_Dv) nxt_state = DONE;           // dibit on this cycle is discarded
        else if (Rx_Er) begin
          set_rx_er = 1'b1;
          nxt_state = DROP;
        end else begin
          take_dibit = 1'b1;
          if (dib_cnt == 2'd3) begin
            byte_done = 1'b1;
            if (Fifo_Full) begin
              set_ovf   = 1'b1;
              nxt_state = DROP;
            end else if (byte_cnt >= MAX_BYTES) begin
              set_giant = 1'b1;
              nxt_state = DROP;
            end else begin
              wr_en = 1'b1;
              if (state == DEST_ADDR && byte_cnt == END_DST) nxt_state = SRC_ADDR;
              if (state == SRC_ADDR  && byte_cnt == END_SRC) nxt_state = LEN_TYPE;
              if (state == LEN_TYPE  && byte_cnt == END_LT)  nxt_state = DATA;
            end
          end
        end
      end
      DROP:
        if (!Crs_Dv) nxt_state = DONE;
      DONE:
        nxt_state = IDLE;
      default:
        nxt_state = IDLE;
    endcase
  end

  // Frame status by priority; evaluated on the cycle that enters DONE.
  always_comb begin
    err_code = ERR_NONE;
    if      (rx_er_seen)            err_code = ERR_RX_ER;
    else if (ovf_seen)              err_code = ERR_OVF;
    else if (giant_seen)            err_code = ERR_GIANT;
    else if (dib_cnt != 2'd0)       err_code = ERR_ALIGN;
    else if (byte_cnt < MIN_BYTES)  err_code = ERR_RUNT;
    else if (addr_miss)             err_code = ERR_ADDR;
    else if (crc != CRC_RESIDUE)    err_code = ERR_CRC;
  end

  // State register; Wait_Quiet holds off lock until the line has been idle once.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      wait_quiet <= 1'b1;
    end else begin
      state <= nxt_state;
      if (!Crs_Dv) wait_quiet <= 1'b0;
    end
  end

  // Byte assembly, counters, error flags and registered outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      pre_cnt      <= 8'd0;
      dib_cnt      <= 2'd0;
      byte_buf     <= 6'd0;
      byte_cnt     <= 11'd0;
      rx_er_seen   <= 1'b0;
      ovf_seen     <= 1'b0;
      giant_seen   <= 1'b0;
      Fifo_Wr      <= 1'b0;
      Fifo_Wr_Data <= 8'd0;
      Pkt_Done     <= 1'b0;
      Pkt_Good     <= 1'b0;
      Pkt_Err_Code <= 3'd0;
    end else begin
      Fifo_Wr      <= wr_en;
      if (wr_en) Fifo_Wr_Data <= byte_nxt;
      Pkt_Done     <= 1'b0;
      Pkt_Good     <= 1'b0;
      Pkt_Err_Code <= 3'd0;
      if (nxt_state == DONE) begin
        Pkt_Done     <= 1'b1;
        Pkt_Good     <= (err_code == ERR_NONE);
        Pkt_Err_Code <= err_code;
      end
      if (state == IDLE) begin
        pre_cnt    <= 8'd1;
        dib_cnt    <= 2'd0;
        byte_cnt   <= 11'd0;
        rx_er_seen <= 1'b0;
        ovf_seen   <= 1'b0;
        giant_seen <= 1'b0;
      end
      if (state == PREAMBLE && Rxd == 2'b01 && pre_cnt != 8'hFF)
        pre_cnt <= pre_cnt + 8'd1;
      if (take_dibit) begin
        dib_cnt <= dib_cnt + 2'd1;
        case (dib_cnt)
          2'd0:    byte_buf[1:0] <= Rxd;
          2'd1:    byte_buf[3:2] <= Rxd;
          2'd2:    byte_buf[5:4] <= Rxd;
          default: ;
        endcase
      end
      if (byte_done && byte_cnt != 11'h7FF) byte_cnt <= byte_cnt + 11'd1;
      if (set_rx_er) rx_er_seen <= 1'b1;
      if (set_ovf)   ovf_seen   <= 1'b1;
      if (set_giant) giant_seen <= 1'b1;
    end
  end

`ifdef ETH_RX_ADDR_FILTER_EN
  logic [47:0] mac_sr;
  logic        mac_miss, bc_miss;

  // Step through the local address a byte at a time, wire order (MSB byte first).
  always_ff @(posedge Clk) begin
    if (Rst || state == IDLE) begin
      mac_sr   <= pMAC_Addr;
      mac_miss <= 1'b0;
      bc_miss  <= 1'b0;
    end else if (wr_en && state == DEST_ADDR) begin
      mac_sr <= {mac_sr[39:0], 8'h00};
      if (byte_nxt != mac_sr[47:40]) mac_miss <= 1'b1;
      if (byte_nxt != 8'hFF)         bc_miss  <= 1'b1;
    end
  end

  assign addr_miss = mac_miss && bc_miss;
`else
  // Address is kept as a parameter so both builds share one interface.
  logic unused_mac;
  assign unused_mac = ^pMAC_Addr;
  assign addr_miss  = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// tb_eth_rx_ctrl: table-driven frame vectors plus hand-written reset and
// false-carrier sequences for eth_rx_ctrl.
module tb_eth_rx_ctrl;

  logic        Clk, Rst;
  logic [1:0]  Rxd;
  logic        Crs_Dv, Rx_Er, Fifo_Full;
  logic        Fifo_Wr;
  logic [7:0]  Fifo_Wr_Data;
  logic [3:0]  Rx_Ctrl_FSM_State;
  logic [10:0] Byte_Cnt;
  logic        Pkt_Done, Pkt_Good;
  logic [2:0]  Pkt_Err_Code;

  eth_rx_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Rxd(Rxd), .Crs_Dv(Crs_Dv), .Rx_Er(Rx_Er),
    .Fifo_Full(Fifo_Full), .Fifo_Wr(Fifo_Wr), .Fifo_Wr_Data(Fifo_Wr_Data),
    .Rx_Ctrl_FSM_State(Rx_Ctrl_FSM_State), .Byte_Cnt(Byte_Cnt),
    .Pkt_Done(Pkt_Done), .Pkt_Good(Pkt_Good), .Pkt_Err_Code(Pkt_Err_Code)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  typedef struct {
    string name;
    int    len;       // bytes before FCS
    int    flip;      // byte index to corrupt after FCS, -1 none
    int    rxer_dib;  // post-SFD dibit index carrying Rx_Er, -1 none
    int    full_at;   // byte index from which Fifo_Full is held, -1 none
    int    extra;     // trailing dibits after FCS
    int    pre_n;     // count of 01 dibits before SFD
    int    dest;      // 0 local MAC, 1 broadcast, 2 other
    int    exp_wr;
    int    exp_bc;    // -1 = not checked
    int    exp_code;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] fr [0:2047];
  int n_pass = 0, n_tot = 0;
  int cyc = 0, wr_cnt = 0, wr_base = 0, done_cnt = 0, data_err = 0;
  int first_wr_cyc = 0, b0_cyc = 0;
  int cap_code = 0, cap_good = 0, cap_bc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, clear of the active edge.
  always @(negedge Clk) begin
    if (Fifo_Wr) begin
      if (wr_cnt == wr_base) first_wr_cyc = cyc;
      if (wr_cnt - wr_base < 2048 && Fifo_Wr_Data !== fr[wr_cnt - wr_base]) data_err++;
      wr_cnt++;
    end
    if (Pkt_Done) begin
      done_cnt++;
      cap_code = int'(Pkt_Err_Code);
      cap_good = int'(Pkt_Good);
      cap_bc   = int'(Byte_Cnt);
    end
  end

  task automatic check(input string nm, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic drive(input logic [1:0] d, input logic dv, input logic er, input logic full);
    @(negedge Clk);
    Rxd = d; Crs_Dv = dv; Rx_Er = er; Fifo_Full = full;
  endtask

  // Frame body: dest, src, type, counting payload; FCS appended LSB first.
  task automatic build(input int len, input int dest, input int flip);
    logic [31:0] c;
    for (int i = 0; i < len; i++) fr[i] = 8'(i * 7 + 3);
    for (int i = 0; i < 6; i++) begin
      case (dest)
        0:       fr[i] = (i == 0) ? 8'h02 : (i == 5) ? 8'h01 : 8'h00;
        1:       fr[i] = 8'hFF;
        default: fr[i] = (i == 0) ? 8'h02 : (i == 5) ? 8'h02 : 8'h00;
      endcase
      fr[6 + i] = (i == 0) ? 8'h02 : (i == 5) ? 8'hAA : 8'h00;
    end
    fr[12] = 8'h08;
    fr[13] = 8'h00;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len; i++)
      for (int b = 0; b < 8; b++)
        if (c[0] ^ fr[i][b]) c = (c >> 1) ^ 32'hEDB88320;
        else                 c = c >> 1;
    c = ~c;
    for (int j = 0; j < 4; j++) fr[len + j] = c[8*j +: 8];
    if (flip >= 0) fr[flip] = fr[flip] ^ 8'h04;
  endtask

  task automatic run_vec(input vec_t v);
    int total, dib, dn0, de0;
    logic full_now;
    build(v.len, v.dest, v.flip);
    total   = v.len + 4;
    wr_base = wr_cnt;
    dn0     = done_cnt;
    de0     = data_err;
    for (int p = 0; p < v.pre_n; p++) drive(2'b01, 1'b1, 1'b0, 1'b0);
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    dib = 0;
    full_now = 1'b0;
    for (int i = 0; i < total; i++) begin
      if (i == v.full_at) full_now = 1'b1;
      for (int k = 0; k < 4; k++) begin
        drive(fr[i][2*k +: 2], 1'b1, (dib == v.rxer_dib), full_now);
        if (dib == 3) b0_cyc = cyc;
        dib++;
      end
    end
    for (int e = 0; e < v.extra; e++) drive(2'b00, 1'b1, 1'b0, full_now);
    repeat (12) drive(2'b00, 1'b0, 1'b0, 1'b0);
    check({v.name, " done pulses"}, done_cnt - dn0, 1);
    check({v.name, " fifo writes"}, wr_cnt - wr_base, v.exp_wr);
    check({v.name, " err code"}, cap_code, v.exp_code);
    check({v.name, " good"}, cap_good, (v.exp_code == 0) ? 1 : 0);
    check({v.name, " write data"}, data_err - de0, 0);
    if (v.exp_bc >= 0) check({v.name, " byte cnt"}, cap_bc, v.exp_bc);
    if (v.exp_wr > 0)  check({v.name, " wr latency"}, first_wr_cyc - b0_cyc, 1);
  endtask

  task automatic false_carrier(input int n);
    int wm, dn0;
    wm  = wr_cnt;
    dn0 = done_cnt;
    repeat (n) drive(2'b01, 1'b1, 1'b0, 1'b0);
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 1'b1, 1'b0, 1'b0);
    check($sformatf("false carrier %0d state", n), int'(Rx_Ctrl_FSM_State), 0);
    repeat (16) drive(2'b00, 1'b1, 1'b0, 1'b0);
    repeat (8)  drive(2'b00, 1'b0, 1'b0, 1'b0);
    check($sformatf("false carrier %0d writes", n), wr_cnt - wm, 0);
    check($sformatf("false carrier %0d done", n), done_cnt - dn0, 0);
  endtask

  initial begin
    int wm, dn0;
    Rst = 1'b1; Rxd = 2'b00; Crs_Dv = 1'b0; Rx_Er = 1'b0; Fifo_Full = 1'b0;
    repeat (3) @(negedge Clk);
    check("reset state",     int'(Rx_Ctrl_FSM_State), 0);
    check("reset fifo_wr",   int'(Fifo_Wr), 0);
    check("reset pkt_done",  int'(Pkt_Done), 0);
    check("reset byte_cnt",  int'(Byte_Cnt), 0);
    check("reset err_code",  int'(Pkt_Err_Code), 0);
    Rst = 1'b0;
    repeat (2) drive(2'b00, 1'b0, 1'b0, 1'b0);

    //                 name          len  flip rxer full ext pre dst  wr    bc  code
    vecs.push_back('{"good64",       60,  -1,  -1,  -1,  0, 31, 0,   64,   64, 0});
    vecs.push_back('{"crc flip",     60,  30,  -1,  -1,  0, 31, 0,   64,   64, 1});
    vecs.push_back('{"runt40",       36,  -1,  -1,  -1,  0, 31, 0,   40,   40, 2});
    vecs.push_back('{"runt63",       59,  -1,  -1,  -1,  0, 31, 0,   63,   63, 2});
    vecs.push_back('{"min preamble", 60,  -1,  -1,  -1,  0,  8, 0,   64,   64, 0});
    vecs.push_back('{"rx_er b20",    60,  -1,  80,  -1,  0, 31, 0,   20,   20, 5});
    vecs.push_back('{"align",        60,  -1,  -1,  -1,  2, 31, 0,   64,   64, 4});
    vecs.push_back('{"overflow",     60,  -1,  -1,  29,  0, 31, 0,   29,   -1, 6});
    vecs.push_back('{"rx_er+full",   60,  -1, 123,  30,  0, 31, 0,   30,   30, 5});
    vecs.push_back('{"max1518",    1514,  -1,  -1,  -1,  0, 31, 0, 1518, 1518, 0});
    vecs.push_back('{"giant1600",  1596,  -1,  -1,  -1,  0, 31, 0, 1518, 1519, 3});
`ifdef ETH_RX_ADDR_FILTER_EN
    vecs.push_back('{"dest local",   60,  -1,  -1,  -1,  0, 31, 0,   64,   64, 0});
    vecs.push_back('{"dest bcast",   60,  -1,  -1,  -1,  0, 31, 1,   64,   64, 0});
    vecs.push_back('{"dest other",   60,  -1,  -1,  -1,  0, 31, 2,   64,   64, 7});
`endif
    foreach (vecs[i]) run_vec(vecs[i]);

    false_carrier(5);
    false_carrier(7);

    // Reset in the middle of DATA while carrier stays up.
    build(60, 0, -1);
    wr_base = wr_cnt;
    dn0 = done_cnt;
    wm  = wr_cnt;
    repeat (31) drive(2'b01, 1'b1, 1'b0, 1'b0);
    drive(2'b11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 4; k++) begin
        drive(fr[i][2*k +: 2], 1'b1, 1'b0, 1'b0);
        if (i == 30 && k == 1) Rst = 1'b1;
        if (i == 30 && k == 3) begin
          Rst = 1'b0;
          check("mid-frame reset state", int'(Rx_Ctrl_FSM_State), 0);
        end
        if (i == 31 && k == 0) wm = wr_cnt;
      end
    repeat (12) drive(2'b00, 1'b0, 1'b0, 1'b0);
    check("post-reset writes", wr_cnt - wm, 0);
    check("post-reset done",   done_cnt - dn0, 0);
    run_vec('{"after reset", 60, -1, -1, -1, 0, 31, 0, 64, 64, 0});

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/eth_rx_ctrl.md
Name: eth_rx_ctrl

Overview:
- RMII receive-side control for simpleEthernet; counterpart of the transmit control path.
- Samples 2-bit RMII dibits from the PHY, locks to preamble/SFD, and assembles bytes LSB-first.
- Writes every post-SFD byte (header, payload, FCS) into the rx FIFO.
- Runs a CRC-32 residue check; at frame end it reports one done pulse with a good/error status for the downstream packet consumer.

Parameters:
- pMin_Preamble_Dibits, 8, minimum count of consecutive 01 dibits before the 11 SFD dibit is accepted.
- pMin_Frame_Bytes, 64, minimum post-SFD byte count including FCS.
- pMax_Frame_Bytes, 1518, maximum post-SFD byte count including FCS.
- pMAC_Addr, 48'h02_00_00_00_00_01, local MAC address; used only with the optional feature.

Ports:
- Clk  in  1  50 MHz RMII reference clock.
- Rst  in  1  reset; synchronous, active-high.
- Rxd  in  2  RMII receive dibit.
- Crs_Dv  in  1  RMII carrier sense / data valid.
- Rx_Er  in  1  PHY receive error.
- Fifo_Full  in  1  rx FIFO full.
- Fifo_Wr  out  1  one-cycle FIFO write strobe.
- Fifo_Wr_Data  out  8  assembled byte.
- Rx_Ctrl_FSM_State  out  4  current state, for debug.
- Byte_Cnt  out  11  post-SFD bytes received; saturates at 2047.
- Pkt_Done  out  1  one-cycle end-of-frame pulse.
- Pkt_Good  out  1  valid with Pkt_Done; 1 = frame passed all checks.
- Pkt_Err_Code  out  3  valid with Pkt_Done; 0 none, 1 CRC, 2 runt, 3 giant, 4 alignment, 5 Rx_Er, 6 FIFO overflow, 7 address mismatch.

Behaviour:
- Reset values:
  - Rx_Ctrl_FSM_State = IDLE.
  - All outputs 0, Byte_Cnt = 0.
  - CRC register = 32'hFFFFFFFF.
  - Internal flag Wait_Quiet = 1.
- Wait_Quiet: while set, the block ignores input until Crs_Dv is sampled 0, then clears. It is never set again except by Rst, so reset mid-frame never locks onto a partial frame.
- State encodings:
  - IDLE = 0, PREAMBLE = 1, DEST_ADDR = 3, SRC_ADDR = 4, LEN_TYPE = 5, DATA = 6, DONE = 8, DROP = 9.
  - Unused codes go to IDLE.
- IDLE:
  - Clears counters and CRC.
  - Crs_Dv = 1 and Rxd = 01 → PREAMBLE, with preamble count = 1.
- PREAMBLE:
  - Rxd = 01: count increments, saturating.
  - Rxd = 11 with count ≥ pMin_Preamble_Dibits → DEST_ADDR.
  - Any other dibit, short count, or Crs_Dv = 0 → IDLE silently. No Pkt_Done is issued for a false carrier.
- Byte assembly, from DEST_ADDR through DATA:
  - Dibit k (0..3) lands in bits [2k+1:2k].
  - When the 4th dibit is sampled, on the next edge: Fifo_Wr_Data = byte, Fifo_Wr = 1 for one cycle, Byte_Cnt increments, and CRC (reflected, poly 0xEDB88320) advances by that byte.
  - Latency: 1 cycle from the 4th dibit to Fifo_Wr.
- Field transitions:
  - DEST_ADDR → SRC_ADDR after 6 bytes.
  - SRC_ADDR → LEN_TYPE after 6 bytes.
  - LEN_TYPE → DATA after 2 bytes.
  - DATA holds payload plus FCS; it is not separated in real time.
- End of frame: Crs_Dv sampled 0 in any field state → DONE. The dibit sampled on that cycle is discarded.
- Error priority in DONE, highest first:
  1. Rx_Er seen.
  2. Overflow.
  3. Giant.
  4. Alignment (partial byte pending).
  5. Runt (Byte_Cnt < pMin_Frame_Bytes).
  6. Address mismatch.
  7. CRC (register ≠ residue 32'hDEBB20E3).
- DONE:
  - Asserts Pkt_Done for 1 cycle.
  - Pkt_Good = (code == 0).
  - → IDLE.
- Immediate drops:
  - Rx_Er = 1 with Crs_Dv = 1 → DROP.
  - Fifo_Full = 1 on a write cycle → byte is not written, DROP.
  - Byte_Cnt exceeding pMax_Frame_Bytes → DROP.
- DROP:
  - No FIFO writes; the first error is latched.
  - Crs_Dv = 0 → DONE.
- The FIFO is never rewound. The consumer discards FIFO contents for any frame with Pkt_Good = 0.
- Simultaneous events:
  - Crs_Dv falling on a byte-completing dibit: that dibit is discarded, so the frame reports alignment error.
  - Rx_Er together with Fifo_Full: code 5.

Optional Feature:
- Macro: ETH_RX_ADDR_FILTER_EN.
- Defined:
  - The 6 destination bytes are compared, as received, against pMAC_Addr and FF:FF:FF:FF:FF:FF.
  - On a mismatch, the frame proceeds but ends with code 7 and Pkt_Good = 0.
- Undefined:
  - No comparison; code 7 is never produced.
  - pMAC_Addr is unused.

Decomposition:
- Shared package eth_rx_pkg.vh holds:
  - State encodings.
  - Field byte counts: pMAC_Addr_Cnt = 6, pLen_Type_Cnt = 2.
  - Error code constants, the CRC polynomial and the residue constant.
- One sub-module, eth_rx_crc32:
  - Byte-wide reflected CRC-32 with Init, En and Data[7:0] inputs.
  - Crc[31:0] output registered one cycle after En.

Test Plan:
- Good frame: 31×01 + 11 preamble/SFD, 60 bytes, correct FCS → 64 Fifo_Wr pulses, Byte_Cnt = 64, Pkt_Done with Pkt_Good = 1, code 0.
- CRC error: same frame with one payload bit flipped → Pkt_Good = 0, code 1. Runt: 40-byte frame with valid FCS → code 2.
- Rx_Er and alignment:
  - Rx_Er pulsed at byte 20 → FIFO writes stop, Pkt_Done at Crs_Dv fall, code 5.
  - Crs_Dv dropped 2 dibits into a byte → code 4.
- Overflow: Fifo_Full held from byte 30 → no writes after byte 29, code 6. Giant: 1600-byte frame → DROP at byte 1519, code 3.
- Reset and false carrier:
  - Rst asserted mid-DATA and released while Crs_Dv is still 1 → no writes and no Pkt_Done until Crs_Dv goes low and the next frame arrives.
  - 5×01 then 11 → silent return to IDLE.
- With ETH_RX_ADDR_FILTER_EN:
  - Destination address = pMAC_Addr → good.
  - Destination address = broadcast → good.
  - Destination address = 02:00:00:00:00:02 → code 7.
